// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package disp_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam logic [0:6] SEG_BLANK = 7'b111_1111;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    function automatic logic is_bcd(input logic [3:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot counter and GUARD/SHOW sequencer for the digit scan.
// idx_o/guard_o describe the cycle that starts at the next clock edge.
module scan_tick_gen
    import disp_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int TICK_DIV   = 50000,
    parameter  int GUARD_CYC  = 16,
    localparam int IW         = $clog2(NUM_DIGITS),
    localparam int CW         = $clog2(TICK_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx_o,
    output logic          guard_o,
    output logic          slot_end_o,
    output logic          frame_end_o
);

    scan_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic          slot_end;
    logic          guard_end;
    logic [IW-1:0] idx_inc;

    assign slot_end  = (state_q == SHOW)  && (cnt_q == CW'(TICK_DIV - 1));
    assign guard_end = (state_q == GUARD) && (cnt_q == CW'(GUARD_CYC - 1));
    assign idx_inc   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                GUARD: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (guard_end) state_q <= SHOW;
                end
                SHOW: begin
                    if (slot_end) begin
                        state_q <= GUARD;
                        cnt_q   <= '0;
                        idx_q   <= idx_inc;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= GUARD;
            endcase
        end
    end

    // Look-ahead lets the top register an_n/seg_n in step with the FSM.
    assign idx_o       = slot_end ? idx_inc : idx_q;
    assign guard_o     = slot_end || ((state_q == GUARD) && !guard_end);
    assign slot_end_o  = slot_end;
    assign frame_end_o = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-aligned load.
// Define DISP_LZB_EN to enable leading-zero blanking.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int TICK_DIV   = 50000,
    parameter  int GUARD_CYC  = 16,
    localparam int IW         = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    output logic [3:0]              dec_bcd,
    input  logic [0:6]              dec_seg,
    output logic [0:6]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    logic [NUM_DIGITS-1:0][3:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]      act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0][3:0] pend_data_q;
    logic [NUM_DIGITS-1:0]      pend_blank_q;
    logic                       pend_full_q;
    logic [3:0]                 dec_bcd_q;
    logic [0:6]                 seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]      an_n_q, an_n_d;
    logic [NUM_DIGITS-1:0]      dark;

    logic [IW-1:0] idx_nxt;
    logic          guard_nxt;
    logic          slot_end;
    logic          frame_end;
    logic          commit;

    scan_tick_gen #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .GUARD_CYC  (GUARD_CYC)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_o       (idx_nxt),
        .guard_o     (guard_nxt),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end)
    );

    assign load_ready = !pend_full_q;
    assign commit     = frame_end && pend_full_q;

    always_comb begin
        act_data_d  = act_data_q;
        act_blank_d = act_blank_q;
        if (commit) begin
            act_data_d  = pend_data_q;
            act_blank_d = pend_blank_q;
        end
    end

`ifdef DISP_LZB_EN
    logic [NUM_DIGITS-1:0] hi_zero;

    // hi_zero[k]: digit k and every digit above it are zero.
    always_comb begin : lz_scan
        logic hz;
        hz      = 1'b1;
        hi_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            hz         = hz && (act_data_q[k] == 4'd0);
            hi_zero[k] = hz;
        end
    end

    assign dark = act_blank_q | (hi_zero & ~NUM_DIGITS'(1));
`else
    assign dark = act_blank_q;
`endif

    // dec_bcd is already stable when SHOW is entered, so dec_seg has settled.
    always_comb begin
        an_n_d  = '1;
        seg_n_d = SEG_BLANK;
        if (!guard_nxt && !dark[idx_nxt]) begin
            an_n_d[idx_nxt] = 1'b0;
            if (is_bcd(dec_bcd_q)) seg_n_d = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data_q   <= '0;
            act_blank_q  <= '1;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_full_q  <= 1'b0;
            dec_bcd_q    <= 4'd0;
            an_n_q       <= '1;
            seg_n_q      <= SEG_BLANK;
        end else begin
            act_data_q  <= act_data_d;
            act_blank_q <= act_blank_d;
            if (commit) begin
                pend_full_q <= 1'b0;
            end else if (load_valid && !pend_full_q) begin
                pend_data_q  <= load_data;
                pend_blank_q <= load_blank;
                pend_full_q  <= 1'b1;
            end
            if (slot_end) dec_bcd_q <= act_data_d[idx_nxt];
            an_n_q  <= an_n_d;
            seg_n_q <= seg_n_d;
        end
    end

    assign dec_bcd = dec_bcd_q;
    assign seg_n   = seg_n_q;
    assign an_n    = an_n_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized scoreboard bench for display_scan_ctrl against a time-based display model.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int T     = 8;
    localparam int G     = 2;
    localparam int FRAME = N * T;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [15:0]  load_data = '0;
    logic [3:0]   load_blank = '0;
    logic [3:0]   dec_bcd;
    logic [0:6]   dec_seg;
    logic [0:6]   seg_n;
    logic [3:0]   an_n;

    int tests = 0;
    int fails = 0;

    // Scoreboard state: accepted loads waiting for their frame commit.
    logic [19:0]  exp_q[$];
    int           e = 0;
    logic         pend_m = 1'b0;
    logic         acc_m = 1'b0;
    logic [3:0]   m_dig[N];
    logic [3:0]   m_blk = 4'hF;

    always #5 clk = ~clk;

    function automatic logic [0:6] seg7(input logic [3:0] b);
        case (b)
            4'd0: return 7'b000_0001;
            4'd1: return 7'b100_1111;
            4'd2: return 7'b001_0010;
            4'd3: return 7'b000_0110;
            4'd4: return 7'b100_1100;
            4'd5: return 7'b010_0100;
            4'd6: return 7'b010_0000;
            4'd7: return 7'b000_1111;
            4'd8: return 7'b000_0000;
            4'd9: return 7'b000_0100;
            default: return 7'b011_0000;
        endcase
    endfunction

    assign dec_seg = seg7(dec_bcd);

    display_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(T), .GUARD_CYC(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_blank (load_blank),
        .dec_bcd    (dec_bcd),
        .dec_seg    (dec_seg),
        .seg_n      (seg_n),
        .an_n       (an_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    function automatic logic digit_dark(input int s);
        logic lz;
        lz = 1'b0;
`ifdef DISP_LZB_EN
        if (s > 0) begin
            lz = 1'b1;
            for (int j = s; j < N; j++) if (m_dig[j] != 4'd0) lz = 1'b0;
        end
`endif
        return m_blk[s] || lz;
    endfunction

    // Monitor: every cycle the expected display follows from the edge count.
    always @(negedge clk) begin
        if (!rst_n) begin
            e      = 0;
            pend_m = 1'b0;
            acc_m  = 1'b0;
            m_blk  = 4'hF;
            for (int j = 0; j < N; j++) m_dig[j] = 4'd0;
            exp_q.delete();
            chk("rst_an_n", 32'(an_n), 32'hF);
            chk("rst_seg_n", 32'(seg_n), 32'h7F);
            chk("rst_dec_bcd", 32'(dec_bcd), 32'h0);
            chk("rst_load_ready", 32'(load_ready), 32'h1);
        end else begin
            int pos, s;
            logic dk;
            logic [0:6] exp_seg;
            logic [3:0] exp_an;
            logic [19:0] ent;
            e++;
            if ((e % FRAME == 0) && pend_m) begin
                if (exp_q.size() == 0) begin
                    chk("commit_queue_empty", 32'd0, 32'd1);
                end else begin
                    ent = exp_q.pop_front();
                    m_blk = ent[19:16];
                    for (int j = 0; j < N; j++) m_dig[j] = ent[4*j +: 4];
                end
                pend_m = 1'b0;
            end else if (acc_m) begin
                pend_m = 1'b1;
            end
            pos = e % T;
            s   = (e / T) % N;
            dk  = (pos < G) || digit_dark(s);
            exp_an  = dk ? 4'hF : ~(4'b0001 << s);
            exp_seg = (dk || m_dig[s] > 4'd9) ? 7'h7F : seg7(m_dig[s]);
            chk("an_n", 32'(an_n), 32'(exp_an));
            chk("seg_n", 32'(seg_n), 32'(exp_seg));
            chk("dec_bcd", 32'(dec_bcd), 32'(m_dig[s]));
            chk("load_ready", 32'(load_ready), 32'(!pend_m));
            acc_m = load_valid && !pend_m;
        end
    end

    // Driver tasks run at posedge+1 so inputs are stable when the monitor samples.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b);
        int budget;
        load_valid = 1'b1;
        load_data  = d;
        load_blank = b;
        budget     = 4 * FRAME;
        while (!load_ready && budget > 0) begin
            step(1);
            budget--;
        end
        if (!load_ready) begin
            chk("load_accept_timeout", 32'd0, 32'd1);
            load_valid = 1'b0;
        end else begin
            step(1);
            exp_q.push_back({b, d});
            load_valid = 1'b0;
        end
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int budget;
        budget = 4 * FRAME;
        while (an_n !== pat && budget > 0) begin
            step(1);
            budget--;
        end
        if (an_n !== pat) chk("wait_an_timeout", 32'(an_n), 32'(pat));
    endtask

    initial begin
        logic [3:0] rb;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1);
        step(64);

        step($urandom_range(0, 40));
        do_load(16'h1234, 4'h0);
        step(2 * FRAME);

        step($urandom_range(0, 40));
        do_load(16'h1111, 4'h0);
        do_load(16'h2222, 4'h0);
        step(2 * FRAME);

        do_load(16'h567B, 4'h0);
        step(2 * FRAME);
        do_load(16'h0050, 4'h0);
        step(2 * FRAME);
        do_load(16'h0000, 4'h0);
        step(2 * FRAME);
        do_load(16'h8421, 4'b0101);
        step(2 * FRAME);

        for (int i = 0; i < 25; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            do_load(16'($urandom), rb);
            step($urandom_range(0, 50));
        end
        step(2 * FRAME);

        // Reset mid-SHOW with a pending load that must never appear.
        do_load(16'h9876, 4'h0);
        step(2 * FRAME);
        wait_an(4'b1110);
        do_load(16'h4321, 4'h0);
        wait_an(4'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an_n", 32'(an_n), 32'hF);
        chk("async_rst_seg_n", 32'(seg_n), 32'h7F);
        chk("async_rst_dec_bcd", 32'(dec_bcd), 32'h0);
        chk("async_rst_load_ready", 32'(load_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1);
        step(3 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
